// File: rtl/ib_lut_mem_nbank_loader_if.sv
// IB-LUT page memory bus: serial load stream, direct write, pipelined read.
// Master drives requests; slave (the memory) returns read data and status.
interface ib_lut_mem_nbank_loader_if #(
  parameter int QUAN_SIZE       = 3,
  parameter int BANK_INTERLEAVE = 4,
  parameter int ADDR_BITWIDTH   = 4,
  parameter int STROBE_BITWIDTH = 2
);
  localparam int PW = QUAN_SIZE * BANK_INTERLEAVE;

  logic                       load_start_i;
  logic [QUAN_SIZE-1:0]       load_word_i;
  logic                       load_valid_i;
  logic                       we_i;
  logic [PW-1:0]              write_data_i;
  logic [ADDR_BITWIDTH-1:0]   access_addr_i;
  logic                       rd_en_i;
  logic [STROBE_BITWIDTH-1:0] read_strobe_i;
  logic [PW-1:0]              read_page_o;
  logic [QUAN_SIZE-1:0]       read_word_o;
  logic                       rd_valid_o;
  logic                       busy_o;
  logic                       load_done_o;

  modport master (
    output load_start_i, load_word_i, load_valid_i,
    output we_i, write_data_i, access_addr_i,
    output rd_en_i, read_strobe_i,
    input  read_page_o, read_word_o, rd_valid_o,
    input  busy_o, load_done_o
  );

  modport slave (
    input  load_start_i, load_word_i, load_valid_i,
    input  we_i, write_data_i, access_addr_i,
    input  rd_en_i, read_strobe_i,
    output read_page_o, read_word_o, rd_valid_o,
    output busy_o, load_done_o
  );
endinterface

// File: rtl/ib_lut_mem_nbank_loader.sv
// N-bank IB-LUT page memory with serial page loader FSM,
// direct page write and a two-stage pipelined page/word read.
module ib_lut_mem_nbank_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int BANK_INTERLEAVE = 4,
  parameter int PAGE_NUM        = 16,
  parameter int ADDR_BITWIDTH   = 4,
  parameter int STROBE_BITWIDTH = 2
) (
  input logic sys_clk,
  input logic rst,
  ib_lut_mem_nbank_loader_if.slave bus
);
  localparam int PW = QUAN_SIZE * BANK_INTERLEAVE;
  localparam int AW = ADDR_BITWIDTH;
  localparam int SW = STROBE_BITWIDTH;
  localparam logic [AW:0]   PAGE_LIM  = PAGE_NUM[AW:0];
  localparam logic [AW-1:0] LAST_PAGE = AW'(PAGE_NUM - 1);
  localparam logic [SW-1:0] LAST_WORD = SW'(BANK_INTERLEAVE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] word_cnt_q, word_cnt_d;
  logic [AW-1:0] page_cnt_q, page_cnt_d;
  logic [PW-1:0] asm_q, asm_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [PW-1:0] mem_wd;
  logic [PW-1:0] mem_q [PAGE_NUM];

  logic          addr_ok;
  logic          rd_acc;
  logic [PW-1:0] rd_page;

  logic [PW-1:0]        s1_page_q;
  logic [SW-1:0]        s1_strb_q;
  logic                 s1_vld_q;
  logic [PW-1:0]        page_q;
  logic [QUAN_SIZE-1:0] word_q, word_d;
  logic                 vld_q;

  assign addr_ok = {1'b0, bus.access_addr_i} < PAGE_LIM;
  assign rd_acc  = (state_q == IDLE) & bus.rd_en_i & ~bus.we_i;
  assign rd_page = addr_ok ? mem_q[bus.access_addr_i] : '0;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    page_cnt_d = page_cnt_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
    mem_wa     = bus.access_addr_i;
    mem_wd     = bus.write_data_i;
    unique case (state_q)
      IDLE: begin
        mem_we = bus.we_i & addr_ok;
        if (bus.load_start_i) begin
          state_d    = LOAD;
          word_cnt_d = '0;
          page_cnt_d = '0;
        end
      end
      LOAD: begin
        if (bus.load_valid_i) begin
          // word k lives in the k-th slot from the MSB end
          for (int k = 0; k < BANK_INTERLEAVE; k++) begin
            if (word_cnt_q == SW'(k))
              asm_d[(BANK_INTERLEAVE-k)*QUAN_SIZE-1 -: QUAN_SIZE] =
                bus.load_word_i;
          end
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            mem_we     = 1'b1;
            mem_wa     = page_cnt_q;
            mem_wd     = asm_d;
            word_cnt_d = '0;
            page_cnt_d = page_cnt_q + 1'b1;
            if (page_cnt_q == LAST_PAGE)
              state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_d = '0;
    for (int k = 0; k < BANK_INTERLEAVE; k++) begin
      if (s1_strb_q == SW'(k))
        word_d = s1_page_q[(BANK_INTERLEAVE-k)*QUAN_SIZE-1 -: QUAN_SIZE];
    end
  end

  // storage is deliberately not reset so an aborted load keeps its pages
  always_ff @(posedge sys_clk) begin
    if (mem_we)
      mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      page_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      page_cnt_q <= page_cnt_d;
      asm_q      <= asm_d;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1_page_q <= '0;
      s1_strb_q <= '0;
      s1_vld_q  <= 1'b0;
      page_q    <= '0;
      word_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      s1_vld_q <= rd_acc;
      if (rd_acc) begin
        s1_page_q <= rd_page;
        s1_strb_q <= bus.read_strobe_i;
      end
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        page_q <= s1_page_q;
        word_q <= word_d;
      end
    end
  end

  assign bus.read_page_o = page_q;
  assign bus.read_word_o = word_q;
  assign bus.rd_valid_o  = vld_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.load_done_o = (state_q == DONE);
endmodule

// File: tb/tb_ib_lut_mem_nbank_loader.sv
// Randomised bench for the N-bank IB-LUT page memory and loader,
// checked against an array/queue reference model.
module tb_ib_lut_mem_nbank_loader;
  localparam int Q  = 3;
  localparam int BI = 4;
  localparam int PN = 16;
  localparam int AW = 4;
  localparam int SW = 2;
  localparam int PW = Q * BI;

  typedef struct {
    logic [PW-1:0] page;
    logic [Q-1:0]  word;
    int            due;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  logic [PW-1:0] ref_mem [PN];
  exp_t          exq [$];
  exp_t          got_e;
  int            words [PN*BI];

  ib_lut_mem_nbank_loader_if #(
    .QUAN_SIZE(Q), .BANK_INTERLEAVE(BI),
    .ADDR_BITWIDTH(AW), .STROBE_BITWIDTH(SW)
  ) bus ();

  ib_lut_mem_nbank_loader #(
    .QUAN_SIZE(Q), .BANK_INTERLEAVE(BI), .PAGE_NUM(PN),
    .ADDR_BITWIDTH(AW), .STROBE_BITWIDTH(SW)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [Q-1:0] sel(logic [PW-1:0] p, int s);
    return Q'(p >> ((BI - 1 - s) * Q));
  endfunction

  function automatic logic [PW-1:0] pack(int p);
    logic [PW-1:0] r = '0;
    for (int k = 0; k < BI; k++)
      r |= PW'(words[p*BI+k] % 8) << ((BI - 1 - k) * Q);
    return r;
  endfunction

  always @(negedge sys_clk) begin
    if (bus.rd_valid_o) begin
      if (exq.size() == 0) begin
        chk("rd_spurious", 1, 0);
      end else begin
        got_e = exq.pop_front();
        chk("rd_page", bus.read_page_o, got_e.page);
        chk("rd_word", bus.read_word_o, got_e.word);
        chk("rd_lat", cyc, got_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic quiet();
    bus.load_start_i = 0;
    bus.load_valid_i = 0;
    bus.we_i = 0;
    bus.rd_en_i = 0;
  endtask

  task automatic push_rd(int a, int s);
    exp_t e;
    e.page = ref_mem[a];
    e.word = sel(ref_mem[a], s);
    e.due  = cyc + 2;
    exq.push_back(e);
  endtask

  task automatic rd(int a, int s);
    bus.rd_en_i = 1;
    bus.access_addr_i = AW'(a);
    bus.read_strobe_i = SW'(s);
    push_rd(a, s);
    tick();
  endtask

  task automatic wr(int a, logic [PW-1:0] d);
    bus.we_i = 1;
    bus.access_addr_i = AW'(a);
    bus.write_data_i = d;
    ref_mem[a] = d;
    tick();
    bus.we_i = 0;
  endtask

  task automatic drain();
    quiet();
    repeat (4) tick();
    chk("drain", exq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, sent, dn, lim;
    logic v;
    quiet();
    bus.load_word_i = 0;
    bus.write_data_i = 0;
    bus.access_addr_i = 0;
    bus.read_strobe_i = 0;
    repeat (2) tick();
    rst = 0;
    tick();

    for (int i = 0; i < PN; i++) wr(i, PW'($urandom));
    drain();

    // reset with a read request held
    rst = 1;
    bus.rd_en_i = 1;
    bus.access_addr_i = 5;
    bus.read_strobe_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs",
          {bus.read_page_o, bus.read_word_o, bus.rd_valid_o,
           bus.busy_o, bus.load_done_o}, 0);
    end
    rst = 0;
    push_rd(5, 1);
    tick();
    chk("rst_no_vld", bus.rd_valid_o, 0);
    drain();

    // serial load, words i mod 8
    for (int i = 0; i < PN*BI; i++) words[i] = i % 8;
    bus.load_start_i = 1;
    t0 = cyc;
    tick();
    bus.load_start_i = 0;
    chk("busy_rise", bus.busy_o, 1);
    dn = 0;
    for (int i = 0; i < PN*BI; i++) begin
      bus.load_valid_i = 1;
      bus.load_word_i = Q'(words[i]);
      tick();
      dn += int'(bus.load_done_o);
      if (bus.load_done_o && cyc - t0 != 65)
        chk("load_done_at", cyc - t0, 65);
    end
    bus.load_valid_i = 0;
    chk("load_done_end", bus.load_done_o, 1);
    chk("load_busy_end", bus.busy_o, 1);
    tick();
    chk("load_done_cnt", dn, 1);
    chk("load_idle", {bus.busy_o, bus.load_done_o}, 0);
    for (int p = 0; p < PN; p++) ref_mem[p] = pack(p);
    rd(1, 2);
    bus.rd_en_i = 0;
    tick();
    chk("p1_page", bus.read_page_o, 12'o4567);
    chk("p1_word", bus.read_word_o, 3'd6);
    drain();

    // strobe sweep
    wr(5, 12'o1234);
    for (int s = 0; s < BI; s++) rd(5, s);
    drain();

    // write/read collision then read-after-write
    bus.we_i = 1;
    bus.rd_en_i = 1;
    bus.access_addr_i = 3;
    bus.write_data_i = 12'o7777;
    ref_mem[3] = 12'o7777;
    tick();
    bus.we_i = 0;
    rd(3, 0);
    drain();

    // mid-load reset after 10 words
    for (int i = 0; i < PN*BI; i++) words[i] = int'($urandom_range(0, 7));
    bus.load_start_i = 1;
    tick();
    bus.load_start_i = 0;
    for (int i = 0; i < 10; i++) begin
      bus.load_valid_i = 1;
      bus.load_word_i = Q'(words[i]);
      tick();
    end
    bus.load_valid_i = 0;
    rst = 1;
    #1;
    chk("mid_rst_busy", bus.busy_o, 0);
    tick();
    rst = 0;
    tick();
    chk("mid_rst_idle", bus.busy_o, 0);
    ref_mem[0] = pack(0);
    ref_mem[1] = pack(1);
    for (int p = 0; p < 3; p++) rd(p, $urandom_range(0, BI-1));
    drain();

    // load with gaps and blocked requests
    for (int i = 0; i < PN*BI; i++) words[i] = int'($urandom_range(0, 7));
    bus.load_start_i = 1;
    tick();
    sent = 0;
    lim = 0;
    while (sent < PN*BI && lim < 1000) begin
      v = ($urandom % 4) != 0;
      bus.load_valid_i = v;
      bus.load_word_i = Q'(words[sent]);
      bus.load_start_i = ($urandom % 5) == 0;
      bus.rd_en_i = $urandom % 2;
      bus.we_i = ($urandom % 3) == 0;
      bus.access_addr_i = AW'($urandom);
      bus.write_data_i = PW'($urandom);
      tick();
      lim++;
      if (v) sent++;
      if (bus.load_done_o && sent < PN*BI)
        chk("gate_early_done", 1, 0);
    end
    chk("gate_sent", sent, PN*BI);
    chk("gate_done", bus.load_done_o, 1);
    bus.load_valid_i = 0;
    bus.load_start_i = 1;
    bus.rd_en_i = 1;
    bus.we_i = 1;
    tick();
    quiet();
    chk("gate_idle", {bus.busy_o, bus.load_done_o}, 0);
    for (int p = 0; p < PN; p++) ref_mem[p] = pack(p);
    for (int p = 0; p < PN; p++) rd(p, $urandom_range(0, BI-1));
    drain();

    // random idle traffic
    for (int i = 0; i < 80; i++) begin
      int a, s;
      logic w, r;
      logic [PW-1:0] d;
      a = int'($urandom_range(0, PN-1));
      s = int'($urandom_range(0, BI-1));
      d = PW'($urandom);
      w = ($urandom % 3) == 0;
      r = $urandom % 2;
      bus.we_i = w;
      bus.rd_en_i = r;
      bus.access_addr_i = AW'(a);
      bus.read_strobe_i = SW'(s);
      bus.write_data_i = d;
      if (w) ref_mem[a] = d;
      else if (r) push_rd(a, s);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
